// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: load/store controller in front of a byte-addressed,
// big-endian data memory. It takes one request at a time from the execute
// stage. It drives the memory for exactly one ACCESS cycle. It then holds
// the response until the consumer accepts it.
//
// Optional build macro: MISALIGN_TRAP_EN
//   When defined, misaligned halfword and word accesses are rejected with
//   resp_err. When undefined, they run byte by byte on the memory, and only
//   the funct3 and range checks can reject a request.

module lsu_dmem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_din,
  output logic                  mem_we0,
  output logic                  mem_we1,
  output logic                  mem_we2,
  input  logic [XLEN-1:0]       mem_dout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_we;
  logic [2:0]              r_funct3;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_err;
  logic [XLEN-1:0]         r_din;
  logic [XLEN-1:0]         r_rdata;
  logic                    r_resp_err;

  logic                    w_req_err;
  logic                    w_accept;
  logic                    w_store_go;

  // Access size minus one, derived from funct3[1:0]:
  // byte gives 0, half gives 1, word gives 3.
  function automatic logic [1:0] f_size_m1(input logic [1:0] width);
    logic [1:0] res;
    case (width)
      2'b00:   res = 2'd0;
      2'b01:   res = 2'd1;
      2'b10:   res = 2'd3;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // Reject illegal encodings, out-of-range addresses and accesses that would
  // wrap past the top of memory.
  function automatic logic f_req_err(input logic            we,
                                     input logic [2:0]      funct3,
                                     input logic [XLEN-1:0] addr);
    logic                  bad_code;
    logic                  high_bits;
    logic                  mis;
    logic [ADDR_WIDTH:0]   last;
    case (funct3)
      3'd3, 3'd6, 3'd7: bad_code = 1'b1;
      3'd4, 3'd5:       bad_code = we;
      default:          bad_code = 1'b0;
    endcase
    high_bits = (addr[XLEN-1:ADDR_WIDTH] != {(XLEN-ADDR_WIDTH){1'b0}});
    last = {1'b0, addr[ADDR_WIDTH-1:0]} +
           {{(ADDR_WIDTH-1){1'b0}}, f_size_m1(funct3[1:0])};
`ifdef MISALIGN_TRAP_EN
    mis = ((funct3[1:0] == 2'b01) && addr[0]) ||
          ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    return bad_code | high_bits | last[ADDR_WIDTH] | mis;
  endfunction

  // Store data is right-aligned on the request side. The memory wants the
  // byte at the lowest address in bits 31:24.
  function automatic logic [XLEN-1:0] f_align_wdata(input logic [1:0]      width,
                                                    input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] res;
    case (width)
      2'b00:   res = {wdata[7:0], 24'd0};
      2'b01:   res = {wdata[15:0], 16'd0};
      2'b10:   res = wdata;
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  // Extract the loaded bytes from the left-aligned memory word, then sign-
  // or zero-extend them according to funct3.
  function automatic logic [XLEN-1:0] f_load_ext(input logic [2:0]      funct3,
                                                 input logic [XLEN-1:0] dout);
    logic [XLEN-1:0] res;
    case (funct3)
      3'd0:    res = {{24{dout[31]}}, dout[31:24]};
      3'd4:    res = {24'd0, dout[31:24]};
      3'd1:    res = {{16{dout[31]}}, dout[31:16]};
      3'd5:    res = {16'd0, dout[31:16]};
      3'd2:    res = dout;
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  assign w_req_err = f_req_err(req_we, req_funct3, req_addr);
  assign w_accept  = (r_state == ST_IDLE) && req_valid;

  // State register; reset drops the FSM to IDLE asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: ACCESS always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only. Because of this, a reset during ACCESS
  // removes the write enables at once, without waiting for a clock edge.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_store_go = 1'b0;
    case (r_state)
      ST_IDLE:   req_ready  = 1'b1;
      ST_ACCESS: w_store_go = r_we && !r_err;
      ST_RESP:   resp_valid = 1'b1;
      default: begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        w_store_go = 1'b0;
      end
    endcase
  end

  assign mem_we0    = w_store_go;
  assign mem_we1    = w_store_go && (r_funct3[1:0] != 2'b00);
  assign mem_we2    = w_store_go && (r_funct3[1:0] == 2'b10);
  assign mem_addr   = r_addr;
  assign mem_din    = r_din;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_resp_err;

  // Request latch and response registers, advanced according to the FSM
  // phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= {ADDR_WIDTH{1'b0}};
      r_err      <= 1'b0;
      r_din      <= {XLEN{1'b0}};
      r_rdata    <= {XLEN{1'b0}};
      r_resp_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[ADDR_WIDTH-1:0];
            r_err    <= w_req_err;
            r_din    <= (req_we && !w_req_err) ?
                        f_align_wdata(req_funct3[1:0], req_wdata) :
                        {XLEN{1'b0}};
          end
        end
        ST_ACCESS: begin
          r_resp_err <= r_err;
          r_rdata    <= (!r_we && !r_err) ? f_load_ext(r_funct3, mem_dout) :
                                            {XLEN{1'b0}};
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_rdata    <= {XLEN{1'b0}};
            r_resp_err <= 1'b0;
          end
        end
        default: begin
          r_rdata    <= {XLEN{1'b0}};
          r_resp_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Testbench for lsu_dmem_ctrl. The bench contains a byte-array model of
// the big-endian data memory, which the DUT drives. A second, independent
// byte array is the reference image. The reference image is updated from
// the load/store rules at transaction level.

module tb_lsu_dmem_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we0;
  logic        mem_we1;
  logic        mem_we2;
  logic [31:0] mem_dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem     [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic       tb_init;

  lsu_dmem_ctrl #(.ADDR_WIDTH(AW), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we0    (mem_we0),
    .mem_we1    (mem_we1),
    .mem_we2    (mem_we2),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Data memory attached to the DUT: three write enables, combinational read.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_byte(i);
    end else begin
      if (mem_we0) mem[mem_addr] <= mem_din[31:24];
      if (mem_we1) mem[AW'(mem_addr + 1)] <= mem_din[23:16];
      if (mem_we2) begin
        mem[AW'(mem_addr + 2)] <= mem_din[15:8];
        mem[AW'(mem_addr + 3)] <= mem_din[7:0];
      end
    end
  end

  always_comb begin
    mem_dout = {mem[mem_addr], mem[AW'(mem_addr + 1)],
                mem[AW'(mem_addr + 2)], mem[AW'(mem_addr + 3)]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the number of bytes touched by an access.
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    longint unsigned a;
    int sz;
    a  = longint'(addr);
    sz = acc_size(f3);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if (a >= DEPTH) return 1'b1;
    if (a + longint'(sz) - 1 > DEPTH - 1) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (sz > 1 && (a % longint'(sz)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    longint unsigned v;
    int sz;
    sz = acc_size(f3);
    v  = 0;
    for (int i = 0; i < sz; i++) v = (v << 8) | longint'(ref_mem[int'(addr) + i]);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v + 64'hFFFF_FFFF - ((longint'(1) << (8 * sz)) - 1);
    return v[31:0];
  endfunction

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    bit          e;
    int          sz;
    logic [31:0] exp_rdata;
    logic [31:0] exp_we;
    logic [31:0] exp_din;
    longint unsigned wv;
    e         = model_err(we, f3, addr);
    sz        = acc_size(f3);
    exp_rdata = (!we && !e) ? model_load(f3, addr) : 32'd0;
    exp_we    = (we && !e) ? ((sz == 1) ? 32'd1 : (sz == 2) ? 32'd3 : 32'd7) : 32'd0;
    wv        = longint'(wdata) & ((longint'(1) << (8 * sz)) - 1);
    exp_din   = 32'(wv << (32 - 8 * sz));

    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_wdata  = $urandom;
    check("acc_we", {29'd0, mem_we2, mem_we1, mem_we0}, exp_we);
    check("acc_addr", {22'd0, mem_addr}, addr & 32'h3FF);
    if (we && !e) check("acc_din", mem_din, exp_din);
    check("acc_req_ready", {31'd0, req_ready}, 32'd0);
    check("acc_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_err", {31'd0, resp_err}, {31'd0, e});
    for (int h = 0; h < hold; h++) begin
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h0000_0100;
      req_wdata  = $urandom;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, exp_rdata);
      check("hold_err", {31'd0, resp_err}, {31'd0, e});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_we", {29'd0, mem_we2, mem_we1, mem_we0}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("done_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("done_rdata_clr", resp_rdata, 32'd0);
    check("done_err_clr", {31'd0, resp_err}, 32'd0);
    check("done_req_ready", {31'd0, req_ready}, 32'd1);
    if (we && !e) begin
      for (int i = 0; i < sz; i++)
        ref_mem[int'(addr) + i] = 8'(wv >> (8 * (sz - 1 - i)));
    end
  endtask

  task automatic reset_in_access(input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_pre_we", {29'd0, mem_we2, mem_we1, mem_we0}, 32'd7);
    rst_n = 1'b0;
    #1;
    check("rst_async_we", {29'd0, mem_we2, mem_we1, mem_we0}, 32'd0);
    check("rst_async_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("rst_still_idle", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [2:0]  f3;
    logic [31:0] a;
    logic        we;
    rst_n      = 1'b0;
    tb_init    = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_mem_we", {29'd0, mem_we2, mem_we1, mem_we0}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    tb_init = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the test plan.
    do_txn(1'b1, 3'd2, 32'h10, 32'h11223344, 0);
    do_txn(1'b0, 3'd2, 32'h10, 32'h0, 0);
    check("lw_0x10_model", model_load(3'd2, 32'h10), 32'h11223344);
    do_txn(1'b1, 3'd0, 32'h21, 32'h000000F0, 0);
    do_txn(1'b0, 3'd0, 32'h21, 32'h0, 0);
    do_txn(1'b0, 3'd4, 32'h21, 32'h0, 0);
    do_txn(1'b1, 3'd1, 32'h30, 32'h00008001, 0);
    do_txn(1'b0, 3'd1, 32'h30, 32'h0, 0);
    do_txn(1'b0, 3'd5, 32'h30, 32'h0, 0);
    do_txn(1'b0, 3'd2, 32'h30, 32'h0, 0);
    do_txn(1'b0, 3'd2, 32'h3FE, 32'h0, 0);
    do_txn(1'b0, 3'd2, 32'h400, 32'h0, 0);
    do_txn(1'b0, 3'd3, 32'h10, 32'h0, 0);
    do_txn(1'b1, 3'd4, 32'h10, 32'hDEADBEEF, 0);
    do_txn(1'b1, 3'd2, 32'h3FC, 32'hCAFEF00D, 0);
    do_txn(1'b0, 3'd2, 32'h3FC, 32'h0, 5);
    do_txn(1'b1, 3'd2, 32'h12, 32'hA5A55A5A, 0);
    do_txn(1'b0, 3'd2, 32'h12, 32'h0, 0);
    do_txn(1'b0, 3'd2, 32'h10, 32'h0, 0);

    reset_in_access(32'h40, 32'h99887766);
    do_txn(1'b0, 3'd2, 32'h40, 32'h0, 0);

    // Random traffic around a small window and the top of memory.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      if ($urandom_range(0, 9) < 8 && !we) f3 = (f3 < 3'd2 && $urandom_range(0, 1) == 1) ? f3 + 3'd4 : f3;
      case ($urandom_range(0, 9))
        0:       a = 32'h400 + 32'($urandom_range(0, 15));
        1:       a = $urandom;
        2, 3:    a = 32'h3F8 + 32'($urandom_range(0, 7));
        default: a = 32'($urandom_range(0, 63));
      endcase
      do_txn(we, f3, a, $urandom, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
